// File: rtl/addatone_pkg.sv
// Shared constants, state encoding, reset values and helpers for the ADC control register block.
package addatone_pkg;

  localparam int unsigned DIV_BIT_DEF       = 11;
  localparam logic [7:0]  MAX_HARMONICS_DEF = 8'd100;
  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned WORD_W            = 16;
  localparam int unsigned NUM_WORDS         = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CLAMP   = 2'd2,
    ST_PENDING = 2'd3
  } state_e;

  // Width-independent part of the control set; scale fields depend on DIV_BIT.
  typedef struct packed {
    logic [WORD_W-1:0] frequency;
    logic [WORD_W-1:0] freq_offset;
    logic [7:0]        harmonic_count;
  } ctrl_base_t;

  localparam logic [WORD_W-1:0] RST_FREQUENCY      = 16'd90;
  localparam logic [WORD_W-1:0] RST_FREQ_OFFSET    = 16'd0;
  localparam logic [7:0]        RST_HARMONIC_COUNT = 8'd1;

  localparam ctrl_base_t RST_CTRL = '{
    frequency:      RST_FREQUENCY,
    freq_offset:    RST_FREQ_OFFSET,
    harmonic_count: RST_HARMONIC_COUNT
  };

  // Zero harmonics would silence the voice, so it is promoted to one.
  function automatic logic [7:0] clamp_harmonics(input logic [WORD_W-1:0] raw,
                                                 input logic [7:0]        max_h);
    logic [7:0] res;
    if (raw == 16'd0) begin
      res = 8'd1;
    end else if (raw > {8'd0, max_h}) begin
      res = max_h;
    end else begin
      res = raw[7:0];
    end
    return res;
  endfunction

  function automatic logic [WORD_W-1:0] force_nonzero(input logic [WORD_W-1:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // Quarter-step glide towards the target; snaps when close so it always lands.
  function automatic logic [WORD_W-1:0] smooth_step(input logic [WORD_W-1:0] cur,
                                                    input logic [WORD_W-1:0] tgt);
    logic signed [WORD_W:0] diff;
    logic signed [WORD_W:0] sum;
    logic [WORD_W-1:0]      res;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if ((diff > -17'sd4) && (diff < 17'sd4)) begin
      res = tgt;
    end else begin
      sum = $signed({1'b0, cur}) + (diff >>> 2);
      res = sum[WORD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_control_regs_if.sv
// Frame bundle from the ADC SPI receiver and the sequencer commit strobe.
interface adc_control_regs_if;

  logic                                                            data_received;
  logic [addatone_pkg::NUM_WORDS-1:0][addatone_pkg::WORD_W-1:0]    data;
  logic                                                            commit;

  modport master (output data_received, output data, output commit);
  modport slave  (input  data_received, input  data, input  commit);

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a registered rising-edge detector (one-cycle pulse).
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Async,
  output logic o_Pulse
);

  localparam int unsigned VW = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [VW-1:0]          r_valid;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   w_sync_out;
  logic                   w_rise;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // r_valid marks stages holding real samples, so a strobe already high at
  // reset release is seen as a level, never as an edge.
  assign w_rise = r_valid[VW-1] & w_sync_out & ~r_prev;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_sync  <= '0;
      r_valid <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= SYNC_STAGES'({r_sync, i_Async});
      r_valid <= VW'({r_valid, 1'b1});
      r_prev  <= w_sync_out;
      r_pulse <= w_rise;
    end
  end

  assign o_Pulse = r_pulse;

endmodule

// File: rtl/adc_control_regs.sv
// ADC frame capture, clamp and shadow/commit control registers.
// Optional macro FREQ_SMOOTH_EN: glide o_Frequency towards the shadow on each commit.
module adc_control_regs
  import addatone_pkg::*;
#(
  parameter int unsigned DIV_BIT       = DIV_BIT_DEF,
  parameter logic [7:0]  MAX_HARMONICS = MAX_HARMONICS_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  input  logic               i_Data_Received,
  input  logic [WORD_W-1:0]  i_Data0,
  input  logic [WORD_W-1:0]  i_Data1,
  input  logic [WORD_W-1:0]  i_Data2,
  input  logic [WORD_W-1:0]  i_Data3,
  input  logic [WORD_W-1:0]  i_Data4,
  input  logic [WORD_W-1:0]  i_Data5,
  input  logic [WORD_W-1:0]  i_Data6,
  input  logic               i_Commit,
  output logic [WORD_W-1:0]  o_Frequency,
  output logic [WORD_W-1:0]  o_Freq_Offset,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0] o_Scale_Initial0,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0] o_Scale_Initial1,
  output logic [7:0]         o_Harmonic_Count,
  output logic               o_Update_Pending,
  output logic               o_Updated
);

  state_e                              r_state;
  logic                                r_held;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    r_cap;

  ctrl_base_t                          r_shadow;
  logic [DIV_BIT-1:0]                  r_sh_hs0;
  logic [DIV_BIT-1:0]                  r_sh_si0;
  logic [DIV_BIT-1:0]                  r_sh_hs1;
  logic [DIV_BIT-1:0]                  r_sh_si1;

  ctrl_base_t                          r_out;
  logic [DIV_BIT-1:0]                  r_hs0;
  logic [DIV_BIT-1:0]                  r_si0;
  logic [DIV_BIT-1:0]                  r_hs1;
  logic [DIV_BIT-1:0]                  r_si1;
  logic                                r_updated;
  logic                                r_pending;

  logic                                w_edge;
  logic                                w_reload;
  logic [WORD_W-1:0]                   w_commit_freq;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Async   (i_Data_Received),
    .o_Pulse   (w_edge)
  );

`ifdef FREQ_SMOOTH_EN
  assign w_commit_freq = smooth_step(r_out.frequency, r_shadow.frequency);
`else
  assign w_commit_freq = r_shadow.frequency;
`endif

  // A fresh edge or one that arrived mid-capture both force a recapture.
  assign w_reload = w_edge | r_held;

  // Only the low DIV_BIT bits of the scale words carry information.
  generate
    if (DIV_BIT < WORD_W) begin : g_scale_unused
      logic w_unused_scale_bits;
      assign w_unused_scale_bits = ^{r_cap[1][WORD_W-1:DIV_BIT], r_cap[2][WORD_W-1:DIV_BIT],
                                     r_cap[3][WORD_W-1:DIV_BIT], r_cap[4][WORD_W-1:DIV_BIT]};
    end
  endgenerate

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state   <= ST_IDLE;
      r_held    <= 1'b0;
      r_cap     <= '0;
      r_shadow  <= RST_CTRL;
      r_sh_hs0  <= '0;
      r_sh_si0  <= '0;
      r_sh_hs1  <= '0;
      r_sh_si1  <= '0;
      r_out     <= RST_CTRL;
      r_hs0     <= '0;
      r_si0     <= '0;
      r_hs1     <= '0;
      r_si1     <= '0;
      r_updated <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_CAPTURE;
            r_held  <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          r_cap   <= {i_Data6, i_Data5, i_Data4, i_Data3, i_Data2, i_Data1, i_Data0};
          r_state <= ST_CLAMP;
          if (w_edge) begin
            r_held <= 1'b1;
          end
        end

        ST_CLAMP: begin
          r_shadow.frequency      <= force_nonzero(r_cap[0]);
          r_shadow.freq_offset    <= r_cap[5];
          r_shadow.harmonic_count <= clamp_harmonics(r_cap[6], MAX_HARMONICS);
          r_sh_hs0                <= r_cap[1][DIV_BIT-1:0];
          r_sh_si0                <= r_cap[2][DIV_BIT-1:0];
          r_sh_hs1                <= r_cap[3][DIV_BIT-1:0];
          r_sh_si1                <= r_cap[4][DIV_BIT-1:0];
          r_pending               <= 1'b1;
          r_state                 <= ST_PENDING;
          if (w_edge) begin
            r_held <= 1'b1;
          end
        end

        ST_PENDING: begin
          // Commit always uses the shadow as it stands; a coincident edge recaptures afterwards.
          if (i_Commit) begin
            r_out.frequency      <= w_commit_freq;
            r_out.freq_offset    <= r_shadow.freq_offset;
            r_out.harmonic_count <= r_shadow.harmonic_count;
            r_hs0                <= r_sh_hs0;
            r_si0                <= r_sh_si0;
            r_hs1                <= r_sh_hs1;
            r_si1                <= r_sh_si1;
            r_updated            <= 1'b1;
          end
          if (w_reload) begin
            r_state   <= ST_CAPTURE;
            r_held    <= 1'b0;
            r_pending <= 1'b0;
          end else if (i_Commit) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign o_Frequency       = r_out.frequency;
  assign o_Freq_Offset     = r_out.freq_offset;
  assign o_Harmonic_Count  = r_out.harmonic_count;
  assign o_Harmonic_Scale0 = r_hs0;
  assign o_Scale_Initial0  = r_si0;
  assign o_Harmonic_Scale1 = r_hs1;
  assign o_Scale_Initial1  = r_si1;
  assign o_Update_Pending  = r_pending;
  assign o_Updated         = r_updated;

endmodule

// File: tb/tb_adc_control_regs.sv
// Self-checking bench for adc_control_regs: vector table plus scoreboard of committed values.
`timescale 1ns/1ps
module tb_adc_control_regs;

  localparam int unsigned DIV_BIT = 11;

  typedef struct packed {
    logic [15:0]        freq;
    logic [15:0]        off;
    logic [DIV_BIT-1:0] hs0;
    logic [DIV_BIT-1:0] si0;
    logic [DIV_BIT-1:0] hs1;
    logic [DIV_BIT-1:0] si1;
    logic [7:0]         cnt;
  } ctrl_t;

  typedef struct packed {
    logic [6:0][15:0] d;
    ctrl_t            sh;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_control_regs_if bus ();

  logic [15:0]        o_Frequency;
  logic [15:0]        o_Freq_Offset;
  logic [DIV_BIT-1:0] o_Harmonic_Scale0;
  logic [DIV_BIT-1:0] o_Scale_Initial0;
  logic [DIV_BIT-1:0] o_Harmonic_Scale1;
  logic [DIV_BIT-1:0] o_Scale_Initial1;
  logic [7:0]         o_Harmonic_Count;
  logic               o_Update_Pending;
  logic               o_Updated;

  adc_control_regs #(
    .DIV_BIT       (DIV_BIT),
    .MAX_HARMONICS (8'd100),
    .SYNC_STAGES   (2)
  ) dut (
    .i_Clock           (clk),
    .i_Reset_n         (rst_n),
    .i_Data_Received   (bus.data_received),
    .i_Data0           (bus.data[0]),
    .i_Data1           (bus.data[1]),
    .i_Data2           (bus.data[2]),
    .i_Data3           (bus.data[3]),
    .i_Data4           (bus.data[4]),
    .i_Data5           (bus.data[5]),
    .i_Data6           (bus.data[6]),
    .i_Commit          (bus.commit),
    .o_Frequency       (o_Frequency),
    .o_Freq_Offset     (o_Freq_Offset),
    .o_Harmonic_Scale0 (o_Harmonic_Scale0),
    .o_Scale_Initial0  (o_Scale_Initial0),
    .o_Harmonic_Scale1 (o_Harmonic_Scale1),
    .o_Scale_Initial1  (o_Scale_Initial1),
    .o_Harmonic_Count  (o_Harmonic_Count),
    .o_Update_Pending  (o_Update_Pending),
    .o_Updated         (o_Updated)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_upd    = 0;
  ctrl_t exp_q[$];
  ctrl_t model;
  vec_t  vecs[6];

  localparam ctrl_t RST_EXP = '{freq: 16'd90, off: 16'd0, hs0: '0, si0: '0, hs1: '0, si1: '0, cnt: 8'd1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_freq(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef FREQ_SMOOTH_EN
    int d;
    d = int'(tgt) - int'(cur);
    if (d > -4 && d < 4) return tgt;
    return 16'(int'(cur) + (d >>> 2));
`else
    return tgt;
`endif
  endfunction

  function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, d4, d5, d6,
                              input logic [15:0] f, o, input logic [10:0] h0, s0, h1, s1,
                              input logic [7:0] c);
    vec_t v;
    v.d  = {d6, d5, d4, d3, d2, d1, d0};
    v.sh = '{freq: f, off: o, hs0: h0, si0: s0, hs1: h1, si1: s1, cnt: c};
    return v;
  endfunction

  function automatic logic [6:0][15:0] frame(input logic [15:0] d0, input logic [15:0] d6);
    return {d6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, d0};
  endfunction

  function automatic ctrl_t shadow_of(input logic [15:0] f, input logic [7:0] c);
    return '{freq: f, off: 16'd0, hs0: '0, si0: '0, hs1: '0, si1: '0, cnt: c};
  endfunction

  // Scoreboard: every o_Updated pulse must match the oldest outstanding commit.
  always @(negedge clk) begin
    if (o_Updated === 1'b1) begin
      ctrl_t e;
      n_upd++;
      if (exp_q.size() == 0) begin
        check("unexpected_update", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("upd_freq", 32'(o_Frequency), 32'(e.freq));
        check("upd_offset", 32'(o_Freq_Offset), 32'(e.off));
        check("upd_hscale0", 32'(o_Harmonic_Scale0), 32'(e.hs0));
        check("upd_sinit0", 32'(o_Scale_Initial0), 32'(e.si0));
        check("upd_hscale1", 32'(o_Harmonic_Scale1), 32'(e.hs1));
        check("upd_sinit1", 32'(o_Scale_Initial1), 32'(e.si1));
        check("upd_count", 32'(o_Harmonic_Count), 32'(e.cnt));
      end
    end
  end

  task automatic wait_pending(input logic lvl, input string name);
    int k = 0;
    while (o_Update_Pending !== lvl && k < 40) begin
      step();
      k++;
    end
    if (o_Update_Pending !== lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: pending timeout, got %0b expected %0b", name, o_Update_Pending, lvl);
    end
  endtask

  task automatic send_frame(input logic [6:0][15:0] d, input string name);
    bus.data          = d;
    bus.data_received = 1'b1;
    wait_pending(1'b0, name);
    wait_pending(1'b1, name);
    bus.data_received = 1'b0;
    step(4);
  endtask

  task automatic expect_commit(input ctrl_t sh);
    ctrl_t e;
    e      = sh;
    e.freq = model_freq(model.freq, sh.freq);
    model  = e;
    exp_q.push_back(e);
  endtask

  task automatic do_commit(input ctrl_t sh);
    expect_commit(sh);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step(3);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_freq"}, 32'(o_Frequency), 32'd90);
    check({name, "_count"}, 32'(o_Harmonic_Count), 32'd1);
    check({name, "_offset"}, 32'(o_Freq_Offset), 32'd0);
    check({name, "_scales"}, 32'({o_Harmonic_Scale0, o_Scale_Initial0, o_Harmonic_Scale1, o_Scale_Initial1}), 32'd0);
    check({name, "_pending"}, 32'(o_Update_Pending), 32'd0);
    check({name, "_updated"}, 32'(o_Updated), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int upd0;
    vecs[0] = mk(16'd440, 16'hF123, 16'h0456, 16'h07FF, 16'h0800, 16'h0010, 16'd250,
                 16'd440, 16'h0010, 11'h123, 11'h456, 11'h7FF, 11'h000, 8'd100);
    vecs[1] = mk(16'd0, 16'h0001, 16'hFFFF, 16'h1234, 16'h0ABC, 16'hFFFF, 16'd0,
                 16'd1, 16'hFFFF, 11'h001, 11'h7FF, 11'h234, 11'h2BC, 8'd1);
    vecs[2] = mk(16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'd100,
                 16'hFFFF, 16'hABCD, 11'h000, 11'h000, 11'h000, 11'h000, 8'd100);
    vecs[3] = mk(16'h1234, 16'h07FF, 16'h0555, 16'h02AA, 16'h0001, 16'h0000, 16'd99,
                 16'h1234, 16'h0000, 11'h7FF, 11'h555, 11'h2AA, 11'h001, 8'd99);
    vecs[4] = mk(16'd1, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'd101,
                 16'd1, 16'h0006, 11'h002, 11'h003, 11'h004, 11'h005, 8'd100);
    vecs[5] = mk(16'd90, 16'h3800, 16'h4001, 16'h0000, 16'h0000, 16'h0001, 16'h0105,
                 16'd90, 16'h0001, 11'h000, 11'h001, 11'h000, 11'h000, 8'd100);

    model             = RST_EXP;
    bus.data          = '0;
    bus.commit        = 1'b0;
    bus.data_received = 1'b1;
    rst_n             = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    check("strobe_high_at_release_pending", 32'(o_Update_Pending), 32'd0);
    bus.data_received = 1'b0;
    step(4);
    check_reset_outputs("reset");
    check("reset_no_update", 32'(n_upd), 32'd0);

    // Commit outside PENDING is ignored.
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step(3);
    check("idle_commit_no_update", 32'(n_upd), 32'd0);
    check("idle_commit_freq", 32'(o_Frequency), 32'd90);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, "table_frame");
      check("table_pending", 32'(o_Update_Pending), 32'd1);
      check("table_hold_freq", 32'(o_Frequency), 32'(model.freq));
      do_commit(vecs[i].sh);
      check("table_pending_cleared", 32'(o_Update_Pending), 32'd0);
    end

    // Two frames before one commit: newest frame wins, single update.
    upd0 = n_upd;
    send_frame(frame(16'd200, 16'd5), "two_frames_a");
    send_frame(frame(16'd300, 16'd5), "two_frames_b");
    do_commit(shadow_of(16'd300, 8'd5));
    check("two_frames_one_update", 32'(n_upd - upd0), 32'd1);

    // Edge lands in the same cycle as commit: old shadow commits, new frame goes pending.
    send_frame(frame(16'd1000, 16'd7), "coincide_a");
    bus.data          = frame(16'd2000, 16'd8);
    bus.data_received = 1'b1;
    step(3);
    expect_commit(shadow_of(16'd1000, 8'd7));
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step(4);
    check("coincide_new_pending", 32'(o_Update_Pending), 32'd1);
    check("coincide_old_committed", 32'(o_Frequency), 32'(model.freq));
    bus.data_received = 1'b0;
    step(4);
    do_commit(shadow_of(16'd2000, 8'd8));

    // Reset while pending discards the shadow.
    send_frame(frame(16'd3333, 16'd9), "reset_pending");
    bus.data_received = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model = RST_EXP;
    step();
    check_reset_outputs("mid_reset");
    bus.data_received = 1'b0;
    step(4);
    upd0 = n_upd;
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step(4);
    check("mid_reset_commit_no_update", 32'(n_upd - upd0), 32'd0);
    check("mid_reset_freq_held", 32'(o_Frequency), 32'd90);

    // 90 -> 490: direct copy, or a glide that must land exactly on 490.
`ifdef FREQ_SMOOTH_EN
    for (int i = 0; i < 30; i++) begin
`else
    for (int i = 0; i < 2; i++) begin
`endif
      send_frame(frame(16'd490, 16'd1), "glide_frame");
      do_commit(shadow_of(16'd490, 8'd1));
    end
    check("glide_converged", 32'(o_Frequency), 32'd490);

    step(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
